// File: rtl/mtm_alu_pkt_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : mtm_alu_pkt_tx_if
//  Description : Word-level valid/ready handshake feeding the mtm_alu packet
//                transmitter. The source drives valid/data/last and the
//                transmitter answers with ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mtm_alu_pkt_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    // Word source side (host / stimulus)
    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    // Transmitter side
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/mtm_alu_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mtm_alu_pkt_tx
//  Description : Serial packet transmitter for the mtm_alu sin pin. Buffers
//                {last,data} words in a FIFO and sends each one as a frame:
//                start 0, type bit, DATA_W bits MSB first, stop 1, followed
//                by GAP_CYCLES idle bits. A command frame is followed by
//                PKT_GAP idle bits and a one-cycle pkt_done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mtm_alu_pkt_tx #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 2,
    parameter int PKT_GAP    = 50
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    mtm_alu_pkt_tx_if.slave s_in,
    output logic            sout,
    output logic            busy,
    output logic            pkt_done
);
    localparam int c_AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_GMAX = (GAP_CYCLES > PKT_GAP) ? GAP_CYCLES : PKT_GAP;
    localparam int c_GW   = (c_GMAX > 0) ? $clog2(c_GMAX + 1) : 1;
    localparam int c_BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [c_AW:0]   c_FULL    = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_GW-1:0] c_GAP_LD  = c_GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [c_GW-1:0] c_PGAP_LD = c_GW'((PKT_GAP > 0) ? PKT_GAP - 1 : 0);
    localparam logic [c_BW-1:0] c_BIT_LD  = c_BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_TYPE  = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_GAP   = 3'd5,
        S_PGAP  = 3'd6
    } state_t;

    // FIFO storage and control
    logic [DATA_W:0]   r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    // Frame engine
    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic              r_is_cmd;
    logic [c_BW-1:0]   r_bitcnt;
    logic [c_BW-1:0]   w_bitcnt_nxt;
    logic [c_GW-1:0]   r_gapcnt;
    logic [c_GW-1:0]   w_gapcnt_nxt;
    logic              w_line;
    logic              w_done_evt;
    logic              w_frame_end;
    logic              r_sout;
    logic              r_done_d;
    logic              r_pkt_done;

    assign w_full         = (r_count == c_FULL);
    assign w_empty        = (r_count == '0);
    assign w_push         = s_in.in_valid && !w_full;
    assign s_in.in_ready  = !w_full;

    assign sout     = r_sout;
    assign pkt_done = r_pkt_done;
    assign busy     = (r_state != S_IDLE) || !w_empty;

    // FIFO payload write; contents need no reset because the pointers are cleared
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_in.in_last, s_in.in_data};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Next-state, line bit and counter updates; frame_end resolves where a frame goes after its gap
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_bitcnt_nxt = r_bitcnt;
        w_gapcnt_nxt = r_gapcnt;
        w_line       = 1'b1;
        w_done_evt   = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_START;
                    w_pop       = 1'b1;
                end
            end
            S_START: begin
                w_line      = 1'b0;
                w_state_nxt = S_TYPE;
            end
            S_TYPE: begin
                w_line       = r_is_cmd;
                w_state_nxt  = S_DATA;
                w_bitcnt_nxt = c_BIT_LD;
            end
            S_DATA: begin
                w_line = r_shift[DATA_W-1];
                if (r_bitcnt == '0) begin
                    w_state_nxt = S_STOP;
                end else begin
                    w_bitcnt_nxt = r_bitcnt - c_BW'(1);
                end
            end
            S_STOP: begin
                if (GAP_CYCLES > 0) begin
                    w_state_nxt  = S_GAP;
                    w_gapcnt_nxt = c_GAP_LD;
                end else begin
                    w_frame_end = 1'b1;
                end
            end
            S_GAP: begin
                if (r_gapcnt == '0) begin
                    w_frame_end = 1'b1;
                end else begin
                    w_gapcnt_nxt = r_gapcnt - c_GW'(1);
                end
            end
            S_PGAP: begin
                if (r_gapcnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_done_evt  = 1'b1;
                end else begin
                    w_gapcnt_nxt = r_gapcnt - c_GW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_frame_end) begin
            if (r_is_cmd) begin
                if (PKT_GAP > 0) begin
                    w_state_nxt  = S_PGAP;
                    w_gapcnt_nxt = c_PGAP_LD;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_done_evt  = 1'b1;
                end
            end else if (!w_empty) begin
                w_state_nxt = S_START;
                w_pop       = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    // State, shift register and registered line; pkt_done is delayed to follow the last idle bit on sout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_is_cmd   <= 1'b0;
            r_bitcnt   <= '0;
            r_gapcnt   <= '0;
            r_sout     <= 1'b1;
            r_done_d   <= 1'b0;
            r_pkt_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_gapcnt   <= w_gapcnt_nxt;
            r_sout     <= w_line;
            r_done_d   <= w_done_evt;
            r_pkt_done <= r_done_d;
            if (w_pop) begin
                {r_is_cmd, r_shift} <= r_mem[r_rd_ptr];
            end else if (r_state == S_DATA) begin
                r_shift <= r_shift << 1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mtm_alu_pkt_tx
//  Description : Directed self-checking bench for mtm_alu_pkt_tx. One
//                instance uses default gaps, a second runs with no gaps.
//                sout/pkt_done/in_ready/busy are logged per cycle and frames
//                are compared against hand-computed bit patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mtm_alu_pkt_tx;
    localparam int LOGN = 4096;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic sout_a, busy_a, done_a;
    logic sout_b, busy_b, done_b;

    mtm_alu_pkt_tx_if #(.DATA_W(8)) if_a ();
    mtm_alu_pkt_tx_if #(.DATA_W(8)) if_b ();

    mtm_alu_pkt_tx #(.DATA_W(8), .FIFO_DEPTH(8), .GAP_CYCLES(2), .PKT_GAP(50)) dut_a (
        .clk(clk), .reset_n(reset_n), .s_in(if_a),
        .sout(sout_a), .busy(busy_a), .pkt_done(done_a)
    );

    mtm_alu_pkt_tx #(.DATA_W(8), .FIFO_DEPTH(8), .GAP_CYCLES(0), .PKT_GAP(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .s_in(if_b),
        .sout(sout_b), .busy(busy_b), .pkt_done(done_b)
    );

    always #5 clk = ~clk;

    // cyc == E during the cycle that follows rising edge number E
    always @(posedge clk) cyc <= cyc + 1;

    logic       la_sout  [LOGN];
    logic       la_done  [LOGN];
    logic       la_ready [LOGN];
    logic       la_busy  [LOGN];
    logic [3:0] la_cnt   [LOGN];
    logic       lb_sout  [LOGN];
    logic       lb_done  [LOGN];

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            la_sout[cyc]  <= sout_a;
            la_done[cyc]  <= done_a;
            la_ready[cyc] <= if_a.in_ready;
            la_busy[cyc]  <= busy_a;
            la_cnt[cyc]   <= dut_a.r_count;
            lb_sout[cyc]  <= sout_b;
            lb_done[cyc]  <= done_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input bit use_b, input int s);
        logic [10:0] r;
        for (int i = 0; i < 11; i++) begin
            r[10-i] = use_b ? lb_sout[s+i] : la_sout[s+i];
        end
        return r;
    endfunction

    function automatic int count_ones(input bit use_b, input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) begin
            if ((use_b ? lb_sout[i] : la_sout[i]) === 1'b1) n++;
        end
        return n;
    endfunction

    task automatic check_frame(input string tag, input bit use_b, input int s,
                               input logic typ, input logic [7:0] d);
        check(tag, 32'(frame_bits(use_b, s)), 32'({1'b0, typ, d, 1'b1}));
    endtask

    task automatic check_ones(input string tag, input bit use_b, input int from, input int to);
        check(tag, 32'(count_ones(use_b, from, to)), 32'(to - from + 1));
    endtask

    // Drive one word so that it is sampled at rising edge number e
    task automatic push(input bit use_b, input int e, input logic [7:0] d, input logic l);
        while (cyc < e - 1) @(negedge clk);
        if (use_b) begin
            if_b.in_valid = 1'b1; if_b.in_data = d; if_b.in_last = l;
        end else begin
            if_a.in_valid = 1'b1; if_a.in_data = d; if_a.in_last = l;
        end
        @(posedge clk);
        #1;
        if_a.in_valid = 1'b0;
        if_b.in_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int   k;
        int   k0;
        int   k2;
        int   r;
        int   s;
        int   acc;
        int   guard;
        int   e;
        int   edges [10];
        logic rdy;

        if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.in_last = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.in_last = 1'b0;
        for (int i = 0; i < 10; i++) edges[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sout",  32'(sout_a), 32'd1);
        check("rst_ready", 32'(if_a.in_ready), 32'd1);
        check("rst_busy",  32'(busy_a), 32'd0);
        check("rst_done",  32'(done_a), 32'd0);
        check("rst_sout_b", 32'(sout_b), 32'd1);
        reset_n = 1'b1;

        // Spaced packet 0x55, 0xAA, cmd 0x01 with 11 idle bits between frames
        k = cyc + 3;
        push(0, k,      8'h55, 1'b0);
        push(0, k + 22, 8'hAA, 1'b0);
        push(0, k + 44, 8'h01, 1'b1);
        wait_cyc(k + 112);
        check("pkt_busy_before", 32'(la_busy[k-1]), 32'd0);
        check("pkt_busy_after",  32'(la_busy[k]), 32'd1);
        check("pkt_idle_before", 32'(la_sout[k+1]), 32'd1);
        check_frame("pkt_f1", 0, k + 2, 1'b0, 8'h55);
        check_ones("pkt_gap1", 0, k + 13, k + 23);
        check_frame("pkt_f2", 0, k + 24, 1'b0, 8'hAA);
        check_ones("pkt_gap2", 0, k + 35, k + 45);
        check_frame("pkt_cmd", 0, k + 46, 1'b1, 8'h01);
        check_ones("pkt_pgap", 0, k + 57, k + 108);
        check("pkt_done_early", 32'(la_done[k+108]), 32'd0);
        check("pkt_done_pulse", 32'(la_done[k+109]), 32'd1);
        check("pkt_done_late",  32'(la_done[k+110]), 32'd0);

        // Data word, long idle, then command: line holds 1 and cmd starts two edges after push
        k = cyc + 3;
        push(0, k,      8'h0F, 1'b0);
        push(0, k + 40, 8'hF0, 1'b1);
        wait_cyc(k + 108);
        check_frame("idle_f1", 0, k + 2, 1'b0, 8'h0F);
        check_ones("idle_hold", 0, k + 13, k + 41);
        check_frame("idle_cmd", 0, k + 42, 1'b1, 8'hF0);
        check("idle_done", 32'(la_done[k+105]), 32'd1);

        // Hold valid for 10 words: FIFO fills, back-to-back frames keep push order
        acc   = 0;
        guard = 0;
        while (acc < 10 && guard < 200) begin
            @(negedge clk);
            if_a.in_valid = 1'b1;
            if_a.in_data  = 8'h10 + 8'(acc);
            if_a.in_last  = (acc == 9);
            rdy = if_a.in_ready;
            e   = cyc + 1;
            @(posedge clk);
            #1;
            if (rdy) begin
                edges[acc] = e;
                acc++;
            end
            guard++;
        end
        if_a.in_valid = 1'b0;
        check("fill_accepted", 32'(acc), 32'd10);
        k0 = edges[0];
        // 8 buffered words plus the first one already popped into the shifter
        check("fill_9th_edge",  32'(edges[8] - k0), 32'd8);
        check("fill_10th_edge", 32'(edges[9] - k0), 32'd15);
        check("fill_ready_hi",  32'(la_ready[k0+7]), 32'd1);
        check("fill_ready_lo",  32'(la_ready[k0+8]), 32'd0);
        check("fill_ready_back", 32'(la_ready[k0+14]), 32'd1);
        check("fill_cnt_first", 32'(la_cnt[k0]), 32'd1);
        check("fill_cnt_pushpop", 32'(la_cnt[k0+1]), 32'd1);
        check("fill_cnt_two",   32'(la_cnt[k0+2]), 32'd2);
        check("fill_cnt_full",  32'(la_cnt[k0+8]), 32'd8);
        s = k0 + 2 + 13 * 9;
        wait_cyc(s + 66);
        for (int i = 0; i < 10; i++) begin
            check_frame($sformatf("fill_frame%0d", i), 0, k0 + 2 + 13 * i,
                        (i == 9), 8'h10 + 8'(i));
        end
        check_ones("fill_pgap", 0, s + 11, s + 62);
        check("fill_done", 32'(la_done[s+63]), 32'd1);

        // No gaps: 33 consecutive frame bits, pkt_done right after the last stop bit
        k = cyc + 3;
        push(1, k,     8'hC3, 1'b0);
        push(1, k + 1, 8'h3C, 1'b0);
        push(1, k + 2, 8'h81, 1'b1);
        wait_cyc(k + 40);
        check("nogap_idle", 32'(lb_sout[k+1]), 32'd1);
        check_frame("nogap_f1", 1, k + 2,  1'b0, 8'hC3);
        check_frame("nogap_f2", 1, k + 13, 1'b0, 8'h3C);
        check_frame("nogap_cmd", 1, k + 24, 1'b1, 8'h81);
        check("nogap_done_early", 32'(lb_done[k+34]), 32'd0);
        check("nogap_done_pulse", 32'(lb_done[k+35]), 32'd1);
        check("nogap_done_late",  32'(lb_done[k+36]), 32'd0);
        check("nogap_line_after", 32'(lb_sout[k+35]), 32'd1);

        // Reset asserted during the data bits of frame 2
        k = cyc + 3;
        push(0, k,     8'h11, 1'b0);
        push(0, k + 1, 8'h22, 1'b0);
        push(0, k + 2, 8'h33, 1'b0);
        while (cyc < k + 20) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_sout",  32'(sout_a), 32'd1);
        check("arst_ready", 32'(if_a.in_ready), 32'd1);
        check("arst_busy",  32'(busy_a), 32'd0);
        check("arst_done",  32'(done_a), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        r  = cyc;
        k2 = r + 12;
        check_frame("arst_f1", 0, k + 2, 1'b0, 8'h11);
        check("arst_midframe", 32'(la_sout[k+20]), 32'd0);
        check("arst_flushed", 32'(la_cnt[r]), 32'd0);
        push(0, k2, 8'h5A, 1'b0);
        wait_cyc(k2 + 32);
        check_ones("arst_no_resume", 0, r, k2 + 1);
        check_frame("arst_fresh", 0, k2 + 2, 1'b0, 8'h5A);
        check_ones("arst_after", 0, k2 + 13, k2 + 30);
        check("arst_idle_busy", 32'(la_busy[k2+20]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
